// File: rtl/ucr_hash_core.sv
`default_nettype none
// ============================================================================
// Module      : ucr_hash_core
// Description : Sequential 24-bit micro-UCR hash engine; one 128-bit block in
//               flight, 16 expansion cycles, 32 rounds, result pulse on ready.
// Revision    : 1.0 - initial release
// ============================================================================
module ucr_hash_core #(
    parameter int         ROUNDS = 32,
    parameter logic [7:0] K_LO   = 8'h99,
    parameter logic [7:0] K_HI   = 8'hA1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         hash_init,
    input  logic         valid,
    input  logic [127:0] block_in,
    output logic [23:0]  hash,
    output logic         hash_ready,
    output logic         busy
);

    localparam logic [4:0] c_ST_IDLE   = 5'b00001;
    localparam logic [4:0] c_ST_EXPAND = 5'b00010;
    localparam logic [4:0] c_ST_ROUND  = 5'b00100;
    localparam logic [4:0] c_ST_FINAL  = 5'b01000;
    localparam logic [4:0] c_ST_DONE   = 5'b10000;

    localparam logic [4:0] c_LAST_IDX  = 5'(ROUNDS - 1);
    localparam logic [4:0] c_K_SWITCH  = 5'd16;
    localparam logic [4:0] c_EXP_START = 5'd16;

    logic [4:0]  r_state;
    logic [4:0]  r_cnt;
    logic [7:0]  r_w [0:31];
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [7:0]  r_c;
    logic [23:0] r_hash;
    logic        r_hash_ready;
    logic        r_busy;

    logic [4:0]  w_im3;
    logic [4:0]  w_im9;
    logic [4:0]  w_im14;
    logic [7:0]  w_exp_word;
    logic [7:0]  w_x;
    logic [7:0]  w_k;
    logic [7:0]  w_c_next;

    // Message-schedule taps wrap naturally in 5 bits; only indices 16..31 are used.
    assign w_im3      = r_cnt - 5'd3;
    assign w_im9      = r_cnt - 5'd9;
    assign w_im14     = r_cnt - 5'd14;
    assign w_exp_word = r_w[w_im3] | (r_w[w_im9] ^ r_w[w_im14]);

    assign w_x        = (r_cnt <= c_K_SWITCH) ? (r_a ^ r_b) : (r_a ^ r_c);
    assign w_k        = (r_cnt <= c_K_SWITCH) ? K_LO : K_HI;
    assign w_c_next   = w_x + w_k + r_w[r_cnt];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_c          <= '0;
            r_hash       <= '0;
            r_hash_ready <= 1'b0;
            r_busy       <= 1'b0;
            for (int j = 0; j < 32; j++) begin
                r_w[j] <= '0;
            end
        end else begin
            r_hash_ready <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (hash_init && valid) begin
                        for (int j = 0; j < 16; j++) begin
                            r_w[j] <= block_in[8*j +: 8];
                        end
                        r_cnt   <= c_EXP_START;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_EXPAND;
                    end
                end
                c_ST_EXPAND: begin
                    r_w[r_cnt] <= w_exp_word;
                    r_cnt      <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_a     <= 8'h01;
                        r_b     <= 8'h89;
                        r_c     <= 8'hFE;
                        r_state <= c_ST_ROUND;
                    end
                end
                c_ST_ROUND: begin
                    r_a   <= r_b ^ r_c;
                    r_b   <= {r_c[3:0], 4'h0};
                    r_c   <= w_c_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == c_LAST_IDX) begin
                        r_state <= c_ST_FINAL;
                    end
                end
                c_ST_FINAL: begin
                    // Feed-forward of the initial chaining values.
                    r_a     <= r_a + 8'h01;
                    r_b     <= r_b + 8'h89;
                    r_c     <= r_c + 8'hFE;
                    r_state <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    r_hash       <= {r_a, r_b, r_c};
                    r_hash_ready <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= c_ST_IDLE;
                end
                default: begin
                    r_busy       <= 1'b0;
                    r_hash_ready <= 1'b0;
                    r_state      <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign hash       = r_hash;
    assign hash_ready = r_hash_ready;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ucr_hash_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_ucr_hash_core
// Description : Self-checking bench for ucr_hash_core against a block-level
//               reference model and a latency/scoreboard model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ucr_hash_core;

    logic         clk        = 1'b0;
    logic         reset      = 1'b1;
    logic         hash_init  = 1'b0;
    logic         valid      = 1'b0;
    logic [127:0] block_in   = '0;
    logic [23:0]  hash;
    logic         hash_ready;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    logic        m_busy    = 1'b0;
    logic        m_ready   = 1'b0;
    logic [23:0] m_hash    = '0;
    logic [23:0] m_pending = '0;
    int          m_elapsed = 0;

    localparam logic [127:0] c_V1 = {32'h00000000, 96'h0123456789ABCDEF01234567};
    localparam logic [127:0] c_V2 = {32'hFFFFFFFF, 96'h0123456789ABCDEF01234567};
    localparam logic [23:0]  c_ZERO_HASH = 24'h707957;

    ucr_hash_core dut (
        .clk        (clk),
        .reset      (reset),
        .hash_init  (hash_init),
        .valid      (valid),
        .block_in   (block_in),
        .hash       (hash),
        .hash_ready (hash_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] ucr_model(input logic [127:0] blk);
        logic [7:0] w [32];
        logic [7:0] a, b, c, x, k, na, nb, h0, h1, h2;
        for (int i = 0; i < 16; i++) w[i] = blk[8*i +: 8];
        for (int i = 16; i < 32; i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
        a = 8'h01; b = 8'h89; c = 8'hFE;
        for (int r = 0; r < 32; r++) begin
            if (r <= 16) begin k = 8'h99; x = a ^ b; end
            else         begin k = 8'hA1; x = a ^ c; end
            na = b ^ c;
            nb = c << 4;
            c  = x + k + w[r];
            a  = na;
            b  = nb;
        end
        h0 = a + 8'h01; h1 = b + 8'h89; h2 = c + 8'hFE;
        return {h0, h1, h2};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: a request taken in idle completes exactly 50 edges later.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 1'b0; m_ready = 1'b0; m_hash = '0; m_elapsed = 0;
        end else begin
            m_ready = 1'b0;
            if (m_busy) begin
                m_elapsed++;
                if (m_elapsed == 50) begin
                    m_hash  = m_pending;
                    m_ready = 1'b1;
                    m_busy  = 1'b0;
                end
            end else if (hash_init && valid) begin
                m_busy    = 1'b1;
                m_elapsed = 0;
                m_pending = ucr_model(block_in);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_hash_ready", {31'b0, hash_ready}, {31'b0, m_ready});
            chk("cyc_busy",       {31'b0, busy},       {31'b0, m_busy});
            chk("cyc_hash",       {8'b0, hash},        {8'b0, m_hash});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [127:0] blk);
        hash_init = 1'b1; valid = 1'b1; block_in = blk;
        tick();
        hash_init = 1'b0; valid = 1'b0; block_in = ~blk;
    endtask

    task automatic wait_ready(output int lat);
        bit seen = 0;
        lat = 0;
        for (int n = 0; n < 60 && !seen; n++) begin
            tick();
            lat++;
            if (hash_ready) seen = 1;
        end
        if (!seen) lat = -1;
    endtask

    task automatic count_ready(input int cycles, output int cnt);
        cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            tick();
            if (hash_ready) cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, cnt;
        logic [23:0] h1, h2;

        // Reset held with a live request strobe.
        #2;
        reset = 1'b0; hash_init = 1'b1; valid = 1'b1; block_in = c_V1;
        #1 chk_en = 1'b1;
        repeat (3) tick();
        chk("rst_hash",  {8'b0, hash}, 32'h0);
        chk("rst_ready", {31'b0, hash_ready}, 32'h0);
        chk("rst_busy",  {31'b0, busy}, 32'h0);
        hash_init = 1'b0; valid = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        chk("post_rst_busy", {31'b0, busy}, 32'h0);

        chk("model_zero", {8'b0, ucr_model('0)}, {8'b0, c_ZERO_HASH});

        // Single all-zero block and its latency.
        request('0);
        wait_ready(lat);
        chk("zero_latency", lat, 50);
        chk("zero_hash", {8'b0, hash}, {8'b0, c_ZERO_HASH});
        tick();
        chk("ready_one_cycle", {31'b0, hash_ready}, 32'h0);

        // Known vectors.
        request(c_V1);
        wait_ready(lat);
        chk("v1_latency", lat, 50);
        chk("v1_hash", {8'b0, hash}, {8'b0, ucr_model(c_V1)});
        h1 = hash;
        repeat (3) tick();
        request(c_V2);
        wait_ready(lat);
        chk("v2_latency", lat, 50);
        chk("v2_hash", {8'b0, hash}, {8'b0, ucr_model(c_V2)});
        h2 = hash;
        chk("v1_v2_differ", {31'b0, (h1 != h2)}, 32'h1);
        repeat (10) tick();
        chk("v2_hold", {8'b0, hash}, {8'b0, h2});

        // Strobe without valid.
        hash_init = 1'b1; valid = 1'b0; block_in = c_V1;
        repeat (3) tick();
        hash_init = 1'b0;
        chk("novalid_busy", {31'b0, busy}, 32'h0);
        count_ready(5, cnt);
        chk("novalid_ready", cnt, 0);

        // Request while busy at E+20 is dropped.
        request(c_V2);
        repeat (19) tick();
        hash_init = 1'b1; valid = 1'b1; block_in = c_V1;
        tick();
        hash_init = 1'b0; valid = 1'b0;
        wait_ready(lat);
        chk("busy_req_latency", lat, 30);
        chk("busy_req_hash", {8'b0, hash}, {8'b0, ucr_model(c_V2)});
        count_ready(60, cnt);
        chk("busy_req_not_queued", cnt, 0);

        // Back-to-back: next request the cycle after ready.
        request(c_V1);
        wait_ready(lat);
        chk("b2b_first_latency", lat, 50);
        request({64'hDEADBEEFCAFEF00D, 64'h0011223344556677});
        wait_ready(lat);
        chk("b2b_second_latency", lat, 50);
        chk("b2b_second_hash", {8'b0, hash},
            {8'b0, ucr_model({64'hDEADBEEFCAFEF00D, 64'h0011223344556677})});

        // Mid-operation reset at E+30.
        request(c_V2);
        repeat (30) tick();
        reset = 1'b0;
        #1;
        chk("midrst_hash", {8'b0, hash}, 32'h0);
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        repeat (2) tick();
        reset = 1'b1;
        count_ready(60, cnt);
        chk("midrst_no_ready", cnt, 0);
        chk("midrst_hash_held", {8'b0, hash}, 32'h0);
        request(c_V1);
        wait_ready(lat);
        chk("midrst_fresh_latency", lat, 50);
        chk("midrst_fresh_hash", {8'b0, hash}, {8'b0, ucr_model(c_V1)});
        repeat (3) tick();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ucr_hash_core.md
Name: ucr_hash_core

Overview:
- Sequential responder for the miner's hash request interface.
- Accepts a 128-bit block on a one-cycle hash_init strobe (qualified by valid) and computes the 24-bit micro-UCR hash over 32 rounds.
- Pulses hash_ready with the result held on hash.
- Sits under the nonce-search controller as its hashing engine; one hash in flight at a time.

Parameters:
- ROUNDS, 32, number of compression rounds (fixed algorithm; values other than 32 unsupported)
- K_LO, 8'h99, round constant for rounds 0..16
- K_HI, 8'hA1, round constant for rounds 17..31

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- hash_init  input  1  one-cycle request strobe
- valid  input  1  qualifies hash_init; request accepted only if both are high
- block_in  input  128  message block; byte i = block_in[8*i+7:8*i], i=0..15
- hash  output  24  result {H0,H1,H2}, H0 in [23:16]; held until the next completion
- hash_ready  output  1  one-cycle pulse, hash valid in the same cycle
- busy  output  1  high from acceptance until the cycle hash_ready is asserted

Behaviour:
- Reset (reset==0, async): state=IDLE, hash=0, hash_ready=0, busy=0, W array cleared, round counter=0.
- IDLE:
  - On a clock edge with hash_init&&valid: latch W[0..15] from block_in bytes, set busy=1, go to EXPAND with i=16.
  - hash_init without valid is ignored.
- EXPAND (16 cycles, one word per cycle):
  - W[i] = W[i-3] | (W[i-9] ^ W[i-14]), 8-bit, for i=16..31.
  - Go to ROUND after i=31; load a=8'h01, b=8'h89, c=8'hFE, r=0.
- ROUND (32 cycles, one round per cycle):
  - k=K_LO and x=a^b when r<=16; k=K_HI and x=a^c when r>=17.
  - Update: a<=b^c; b<=c<<4 (8-bit, upper bits dropped); c<=x+k+W[r] (mod 256).
  - Go to FINAL after r=31.
- FINAL (1 cycle):
  - H0=8'h01+a, H1=8'h89+b, H2=8'hFE+c, each mod 256.
  - hash<={H0,H1,H2}; hash_ready<=1; busy<=0; next state IDLE.
- hash_ready deasserts on the following edge unconditionally.
- Latency: request accepted at edge E → hash_ready high after edge E+50 (16 EXPAND + 32 ROUND + 1 FINAL + 1 capture). Throughput: one hash per 50 cycles minimum.
- Back-to-back: a new hash_init&&valid is accepted in IDLE in the cycle after hash_ready (earliest: the edge after hash_ready's edge).
- hash_init while busy=1 is ignored and not queued; the in-flight hash completes unaffected.
- block_in is sampled only at acceptance; later changes have no effect on the in-flight hash.
- Reset asserted mid-operation aborts immediately:
  - hash returns to 0; no hash_ready pulse is issued.
  - After release, the block requires a fresh hash_init.
- State encoding is one-hot. Illegal state → IDLE with busy=0, hash_ready=0.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles with hash_init=1, valid=1 → hash=0, hash_ready=0, busy=0; release → first accepted request only on a later edge with hash_init&&valid.
- Single hash, latency: block_in=128'h0, pulse hash_init with valid=1 at edge E → busy high E+1..E+50, hash_ready exactly one cycle after edge E+50, hash equals the golden C model for the all-zero block.
- Known vectors: block_in = {32'h00000000, 96'h0123456789ABCDEF01234567} and {32'hFFFFFFFF, same 96 bits} → both hashes match the golden model and differ from each other; hash holds the second value until the next completion.
- Ignored strobes: hash_init=1 with valid=0 → no busy, no ready. hash_init&&valid at edge E+20 of an in-flight hash → no effect; exactly one hash_ready at E+50 with the original block's result.
- Back-to-back: second request issued the cycle after hash_ready → accepted; second hash_ready 50 edges after its acceptance with the correct value.
- Mid-operation reset: assert reset=0 at edge E+30 → hash=0, busy=0, no hash_ready. After release, a fresh request gives the correct result at the 50-cycle latency.
